// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM encodings, handshake levels, width default.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package div_unit_pkg;

   // Default operand width; the result is twice this wide ({remainder, quotient}).
   localparam int DIV_DATA_W = 32;

   // Divider FSM states.
   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   // Levels of ready_o.
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   // Levels of start_i.
   localparam logic DivStart = 1'b1;
   localparam logic DivStop  = 1'b0;

endpackage : div_unit_pkg

// File: rtl/div_unit.sv
// Iterative restoring divider (DIV/DIVU), one quotient bit per cycle, result {rem, quo}.
// Latency: DATA_W+2 cycles from acceptance to ready_o; 2 cycles for a zero divisor.
// Backpressure: start_i is held until ready_o; result is held in END while start_i stays high.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                annul_i,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o
);

   // The counter has to reach DATA_W: steps run at 0..DATA_W-1 and the
   // count of DATA_W is the sign-correction cycle.
   localparam int               CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

   div_state_e          state_q,   state_d;
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   // dvd_q starts as the dividend magnitude; each step shifts one dividend
   // bit out of the top and one quotient bit into the bottom, so after
   // DATA_W steps it holds the unsigned quotient.
   logic [DATA_W-1:0]   dvd_q,     dvd_d;
   logic [DATA_W-1:0]   dvs_q,     dvs_d;
   logic [DATA_W-1:0]   rem_q,     rem_d;
   logic                neg_quo_q, neg_quo_d;
   logic                neg_rem_q, neg_rem_d;
   logic [2*DATA_W-1:0] result_q,  result_d;

   // Step datapath and operand sign handling.
   logic [DATA_W:0]     shifted;
   logic [DATA_W:0]     trial;
   logic                q_bit;
   logic                sign_a;
   logic                sign_b;
   logic [DATA_W-1:0]   quo_fix;
   logic [DATA_W-1:0]   rem_fix;

   // Restoring step: the partial remainder is always below the divisor, so
   // shifted - divisor lies in [-divisor, divisor-1] and fits DATA_W+1 bits
   // in two's complement; its top bit is the borrow.
   always_comb begin
      shifted = {rem_q, dvd_q[DATA_W-1]};
      trial   = shifted - {1'b0, dvs_q};
      q_bit   = ~trial[DATA_W];
      sign_a  = signed_div_i & opdata1_i[DATA_W-1];
      sign_b  = signed_div_i & opdata2_i[DATA_W-1];
      quo_fix = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
      rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
   end

   // Next-state and datapath control; everything holds unless a state says otherwise.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;

      unique case (state_q)
         DivFree: begin
            // Acceptance latches magnitudes and the correction signs so later
            // operand or mode changes on the inputs have no effect.
            if (start_i == DivStart && !annul_i) begin
               dvd_d     = sign_a ? (~opdata1_i + 1'b1) : opdata1_i;
               dvs_d     = sign_b ? (~opdata2_i + 1'b1) : opdata2_i;
               rem_d     = '0;
               cnt_d     = '0;
               neg_quo_d = sign_a ^ sign_b;
               neg_rem_d = sign_a;
               result_d  = '0;
               state_d   = (opdata2_i == '0) ? DivByZero : DivOn;
            end
         end

         DivByZero: begin
            if (annul_i) begin
               state_d = DivFree;
            end else begin
               result_d = '0;
               state_d  = DivEnd;
            end
         end

         DivOn: begin
            if (annul_i) begin
               state_d = DivFree;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               // Signed overflow (most-negative / -1) wraps naturally here:
               // negating 0x80..0 gives 0x80..0.
               result_d = {rem_fix, quo_fix};
               cnt_d    = '0;
               state_d  = DivEnd;
            end else begin
               dvd_d = {dvd_q[DATA_W-2:0], q_bit};
               rem_d = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
               cnt_d = cnt_q + 1'b1;
            end
         end

         DivEnd: begin
            // annul_i is deliberately ignored: the result is already committed.
            if (start_i == DivStop) begin
               result_d = '0;
               state_d  = DivFree;
            end
         end

         default: begin
            state_d = DivFree;
         end
      endcase
   end

   // State and datapath registers with synchronous reset clearing all operands.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= DivFree;
         cnt_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
      end
   end

   // Outputs are only live in END, so partial results never leak out.
   always_comb begin
      ready_o  = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
      result_o = (state_q == DivEnd) ? result_q : '0;
   end

endmodule : div_unit

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed divides, annul/reset/zero-divisor boundaries.
// Latency: checks ready_o rise timing against the acceptance cycle.
// Backpressure: start_i held until ready_o, then dropped.
module tb_div_unit;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic        annul_i;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic [63:0] result_o;
   logic        ready_o;

   div_unit #(.DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   typedef struct {
      logic [63:0] res;
      int          lat;
      int          accept;
      string       name;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit mon_en  = 0;
   logic ready_prev = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every ready_o rising edge against the scoreboard head.
   always @(negedge clk) begin
      sb_entry_t e;
      if (mon_en) begin
         if (ready_o && !ready_prev) begin
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL spurious_ready: got ready_o=1 at cycle %0d, expected no result", cyc);
            end else begin
               e = sb_q.pop_front();
               check({e.name, "_result"}, result_o, e.res);
               check({e.name, "_latency"}, 64'(cyc - e.accept), 64'(e.lat));
            end
         end
         if (!ready_o) check("idle_result_zero", result_o, 64'd0);
      end
      ready_prev <= ready_o;
   end

   // Present a request; optionally hold annul_i for its first cycle, which must block acceptance.
   task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input bit push,
                        input bit annul_first, input string name);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      if (annul_first) begin
         annul_i = 1'b1;
         tick();
         annul_i = 1'b0;
      end
      if (push) sb_q.push_back('{res: exp, lat: lat, accept: cyc, name: name});
      tick();
      // Scramble inputs after acceptance; the latched values must be used.
      opdata1_i    = ~a;
      opdata2_i    = ~b;
      signed_div_i = ~sgn;
   endtask

   task automatic wait_ready(input string name);
      bit seen;
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         if (ready_o) seen = 1;
         else tick();
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s_timeout: got no ready_o in 60 cycles, expected ready_o=1", name);
      end
   endtask

   task automatic finish_req(input string name);
      start_i = 1'b0;
      tick();
      check({name, "_drop_ready"}, 64'(ready_o), 64'd0);
   endtask

   task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input string name);
      issue(sgn, a, b, exp, lat, 1, 0, name);
      wait_ready(name);
      finish_req(name);
   endtask

   initial begin
      bit saw;
      rst          = 1'b1;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      repeat (3) tick();
      check("reset_ready", 64'(ready_o), 64'd0);
      check("reset_result", result_o, 64'd0);
      rst = 1'b0;
      tick();
      mon_en = 1;

      run_div(0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, "divu_100_7");
      run_div(1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34, "div_m7_2");
      run_div(1, 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 34, "div_100_m7");
      run_div(0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 34, "divu_big");
      run_div(0, 32'h12345678, 32'd0, 64'd0, 2, "divu_byzero");

      // Annul during ON: no result, then a fresh request must work.
      issue(0, 32'hFFFFFFFF, 32'd1, 64'd0, 0, 0, 0, "annul_on");
      repeat (10) tick();
      start_i = 1'b0;
      annul_i = 1'b1;
      tick();
      annul_i = 1'b0;
      saw = 0;
      repeat (40) begin
         if (ready_o) saw = 1;
         tick();
      end
      check("annul_on_no_ready", 64'(saw), 64'd0);
      run_div(0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 34, "divu_after_annul");

      // Annul in IDLE delays acceptance by one cycle.
      issue(0, 32'd7, 32'd7, 64'h00000000_00000001, 34, 1, 1, "annul_idle");
      wait_ready("annul_idle");
      finish_req("annul_idle");

      // Signed overflow, held result, annul in END ignored.
      issue(1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, 1, 0, "div_ovf");
      wait_ready("div_ovf");
      repeat (3) begin
         tick();
         check("div_ovf_hold_ready", 64'(ready_o), 64'd1);
         check("div_ovf_hold_result", result_o, 64'h00000000_80000000);
      end
      annul_i = 1'b1;
      tick();
      annul_i = 1'b0;
      check("end_annul_ready", 64'(ready_o), 64'd1);
      check("end_annul_result", result_o, 64'h00000000_80000000);
      finish_req("div_ovf");
      check("div_ovf_drop_result", result_o, 64'd0);

      // Reset during ON discards the operation.
      issue(0, 32'd1000, 32'd3, 64'd0, 0, 0, 0, "rst_on");
      repeat (20) tick();
      rst     = 1'b1;
      start_i = 1'b0;
      tick();
      check("rst_on_ready", 64'(ready_o), 64'd0);
      check("rst_on_result", result_o, 64'd0);
      rst = 1'b0;
      saw = 0;
      repeat (50) begin
         if (ready_o) saw = 1;
         tick();
      end
      check("rst_on_no_ready", 64'(saw), 64'd0);

      repeat (3) tick();
      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_div_unit

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: DATA_W, 32, operand width; result is 2*DATA_W bits.
REQ-002 Reset is rst, synchronous, active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start_i  input  1  divide request from the execute stage, held high until ready_o is seen.
REQ-006 annul_i  input  1  cancel in-flight divide (branch flush or exception).
REQ-007 signed_div_i  input  1  1=DIV (two's complement), 0=DIVU; sampled with start_i.
REQ-008 opdata1_i  input  DATA_W  dividend.
REQ-009 opdata2_i  input  DATA_W  divisor.
REQ-010 result_o  output  2*DATA_W  {remainder, quotient}, i.e. {HI, LO}.
REQ-011 ready_o  output  1  result_o is valid; execute stage writes HI/LO.

Function
REQ-012 The block SHALL implement FSM states IDLE, BYZERO, ON and END.
REQ-013 In IDLE with start_i=1 and annul_i=0, the block SHALL latch the operands and signed_div_i.
- Divisor==0 goes to BYZERO; otherwise goes to ON with iteration counter=0.
- Operand changes after acceptance SHALL be ignored.
REQ-014 When signed_div_i=1, the latched operands SHALL be converted to magnitudes; the original signs SHALL be kept for correction.
REQ-015 ON SHALL perform one restoring shift-subtract step per cycle, for exactly DATA_W steps.
- The step uses a (DATA_W+1)-bit trial subtraction of the divisor from the partial remainder.
- The quotient bit is 1 when the result is non-negative.
REQ-016 After the DATA_W-th step, the FSM SHALL go to END with sign correction applied.
- Quotient is negated when the operand signs differ (signed only).
- Remainder takes the sign of the dividend (signed only).
REQ-017 BYZERO SHALL go to END with result = all zeros on the next cycle.
REQ-018 In END, ready_o SHALL be 1 and result_o SHALL hold the result.
- The FSM remains in END while start_i=1.
- When start_i=0, the FSM returns to IDLE with ready_o=0 and result_o=0.
REQ-019 For a non-zero divisor, ready_o SHALL first rise exactly DATA_W+2 cycles after the cycle in which start_i is accepted.
REQ-020 For a zero divisor, ready_o SHALL first rise exactly 2 cycles after the cycle in which start_i is accepted.
REQ-021 annul_i=1 in BYZERO or ON SHALL return the FSM to IDLE next cycle; no ready_o pulse is produced and no partial result is visible.
REQ-022 annul_i=1 in IDLE SHALL block acceptance in that cycle.
REQ-023 annul_i=1 in END SHALL NOT cancel the completed result.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (wraps, no trap).
REQ-025 Outside END, ready_o SHALL be 0 and result_o SHALL be 0.
REQ-026 start_i held high across END->IDLE SHALL NOT restart the divider.
- A new request requires start_i to be sampled low for at least one cycle first.

Reset
REQ-027 rst=1 SHALL force IDLE, counter=0, ready_o=0, result_o=0 and clear all internal operand registers on the next edge, from any state.
REQ-028 rst SHALL override start_i and annul_i; reset during ON SHALL discard the operation with no ready_o pulse.

Structure
REQ-029 The shared defines SHALL hold the FSM state encodings (DivFree, DivByZero, DivOn, DivEnd), DivResultReady/NotReady, DivStart/Stop and the DATA_W default.
REQ-030 The unit SHALL be a single module with no sub-module; sign conversion and the step subtractor are inline logic.

Verification
REQ-031 DIVU 100/7, start held -> ready_o at cycle +34, result_o=0x00000002_0000000E.
REQ-032 DIV 0xFFFFFFF9 (-7) / 2 -> result_o=0xFFFFFFFF_FFFFFFFD (r=-1, q=-3).
REQ-033 DIVU 0x12345678/0 -> ready_o at cycle +2, result_o=0.
REQ-034 DIVU 0xFFFFFFFF/1, annul_i pulsed at ON step 10 -> FSM in IDLE, ready_o stays 0.
- Then a new DIVU 0xFFFFFFFF/1 -> result_o=0x00000000_FFFFFFFF.
REQ-035 DIV 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000.
- Hold start_i 3 extra cycles: ready_o stays 1.
- Drop start_i: ready_o=0 next cycle.
REQ-036 Assert rst at ON step 20 -> next cycle ready_o=0, result_o=0; no later ready_o without a new start_i.
